led_display_engine: RTL and testbench
=====================================

Name: led_display_engine

Overview:
Parametrised front-panel LED driver, the next generation of the fixed 16-LED control block. It drives N_LEDS outputs split into two regions. The low BAR_WIDTH LEDs show a logarithmic rate bar or a cylon scanner. The high N_FLASH LEDs show pulse-stretched event flashes. The block adds a runtime mode select, an auto cylon-to-rate handover, global PWM brightness, and saturating rate measurement. It sits between TTC/trigger/cluster logic and the board LED pins.

Parameters:
BAR_WIDTH, 8, LEDs in rate/cylon region (>=1)
N_FLASH, 8, event flash LEDs; N_LEDS = BAR_WIDTH + N_FLASH
INC_WIDTH, 11, width of per-cycle increment input
FLASH_CYCLES, 4000000, stretch length of a flash in clock cycles (>=1)
SCAN_DIV, 2000000, clock cycles per cylon step (>=1)
GATE_CYCLES, 40079000, rate measurement window in cycles (>=2)
PWM_BITS, 4, brightness resolution

Ports:
clock  in  1  single design clock
reset  in  1  synchronous, active-high reset
mode_i  in  3  0 OFF, 1 NORMAL, 2 CYLON, 3 AUTO, 4 TEST, 5-7 = OFF
brightness_i  in  PWM_BITS  global duty; 0 = dark, all-ones = full on
event_i  in  N_FLASH  single-cycle event strobes (l1a, bc0, resync, ...)
increment_i  in  INC_WIDTH  count to add this cycle (e.g. cluster count)
auto_clear_i  in  1  re-arms AUTO mode (e.g. ttc_resync)
rate_o  out  32  counts accumulated in last completed gate window
rate_valid_o  out  1  one-cycle strobe when rate_o updates
led_o  out  BAR_WIDTH+N_FLASH  registered LED drive; [BAR_WIDTH-1:0] = bar region

Behaviour:
- Reset: all counters, led_o, rate_o, and rate_valid_o go to 0. Cylon pos=0, dir=up; seen=0; pwm counter=0. Reset has priority over every other input in the same cycle.
- Flash channel k:
  - Cycle with event_i[k]=1 loads cnt_k=FLASH_CYCLES; otherwise cnt_k decrements while nonzero.
  - flash[k]=(cnt_k!=0). An event while active reloads the counter (retrigger extends the flash).
  - The LED rises 2 cycles after the event: counter load, then output register.
- Rate accumulator:
  - 32-bit acc adds increment_i every cycle and saturates at 0xFFFFFFFF; no wrap.
  - Gate counter runs 0..GATE_CYCLES-1.
  - On the terminal cycle: rate_o <= sat(acc + increment_i), acc <= 0, rate_valid_o=1 for that one cycle. The window therefore covers exactly GATE_CYCLES increments.
- Bar value:
  - Registered one cycle after rate_o updates.
  - n = 0 if rate_o==0, else min(BAR_WIDTH, floor(log2(rate_o))+1).
  - bar = thermometer with the low n bits set.
- Cylon:
  - Step strobe every SCAN_DIV cycles.
  - On a step: if dir=up and pos==BAR_WIDTH-1, set dir=down and pos-1; if dir=down and pos==0, set dir=up and pos+1; otherwise move pos in dir.
  - BAR_WIDTH=1: pos stays 0.
  - scan = one-hot(pos).
- AUTO:
  - seen set on any cycle with increment_i!=0.
  - seen cleared by reset or auto_clear_i; auto_clear_i wins if simultaneous with nonzero increment.
  - Bar region shows scan while seen=0, bar once seen=1.
- Composite bar region and flash region by mode:
  - OFF: all 0.
  - NORMAL: bar region = bar; flash region = flash.
  - CYLON: bar region = scan; flash region = flash.
  - AUTO: bar region as described under AUTO; flash region = flash.
  - TEST: all 1.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter.
  - en = (brightness_i==all-ones) || (pwm_cnt < brightness_i).
  - led_o <= composite & {N_LEDS{en}}, registered.
  - A mode or brightness change takes effect on led_o the next cycle.
- Background operation:
  - Rate measurement, flash counters and the cylon scanner run in all modes, including OFF/TEST.
  - rate_o and rate_valid_o are independent of mode.

Test Plan:
All scenarios use BAR_WIDTH=4, N_FLASH=4, FLASH_CYCLES=4, SCAN_DIV=2, GATE_CYCLES=16, PWM_BITS=2, brightness=3.

1. Flash: mode=1, single pulse event_i=4'b0001 at cycle t -> led_o[4]=1 for cycles t+2..t+5, 0 at t+6. A second pulse at t+3 extends the high time through t+8.
2. Rate/log bar: increment_i=1 for 16 cycles -> rate_valid_o pulses once, rate_o=16. Next cycle led_o[3:0]=4'b1111 (n=min(4,5)); with increment_i=0 for the next window -> rate_o=0, bar=4'b0000. Increment 2 total in a window -> bar=4'b0011.
3. Saturation: force acc near max, increment_i=0x7FF every cycle -> rate_o=0xFFFFFFFF, no wrap.
4. Cylon/AUTO: mode=3, increment_i=0 -> led_o[3:0] walks 0001,0010,0100,1000,0100,0010,0001 with one step every 2 cycles. A single increment_i=5 switches the bar region to the bar. Then auto_clear_i pulse -> cylon resumes. auto_clear_i coincident with increment -> seen stays 0.
5. Modes/PWM: mode=4 -> led_o=8'hFF. brightness=1 -> led_o high 1 of every 4 cycles; brightness=0 -> led_o=0; mode=6 -> led_o=0.
6. Reset mid-operation: assert reset during an active flash, at cylon pos=2, with acc=9 -> next cycle led_o=0, rate_o=0, acc restarts at 0, cylon restarts at pos 0 going up.

Source files
------------

// File: rtl/led_display_engine.sv
// Front-panel LED engine: log rate bar / cylon scanner in the low region,
// pulse-stretched event flashes in the high region, global PWM brightness.

module led_flash_stretch #(
    parameter int CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic event_i,
    output logic flash_o
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // A new event reloads the full stretch, so retriggers extend the flash.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (event_i) begin
            cnt_q <= CW'(CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign flash_o = (cnt_q != '0);
endmodule

module led_display_engine #(
    parameter int BAR_WIDTH    = 8,
    parameter int N_FLASH      = 8,
    parameter int INC_WIDTH    = 11,
    parameter int FLASH_CYCLES = 4000000,
    parameter int SCAN_DIV     = 2000000,
    parameter int GATE_CYCLES  = 40079000,
    parameter int PWM_BITS     = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [2:0]                   mode_i,
    input  logic [PWM_BITS-1:0]          brightness_i,
    input  logic [N_FLASH-1:0]           event_i,
    input  logic [INC_WIDTH-1:0]         increment_i,
    input  logic                         auto_clear_i,
    output logic [31:0]                  rate_o,
    output logic                         rate_valid_o,
    output logic [BAR_WIDTH+N_FLASH-1:0] led_o
);
    localparam int N_LEDS = BAR_WIDTH + N_FLASH;
    localparam int GW     = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int SW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PW     = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

    typedef enum logic [2:0] {
        M_OFF    = 3'd0,
        M_NORMAL = 3'd1,
        M_CYLON  = 3'd2,
        M_AUTO   = 3'd3,
        M_TEST   = 3'd4
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [N_FLASH-1:0] flash;

    genvar k;
    generate
        for (k = 0; k < N_FLASH; k++) begin : g_flash
            led_flash_stretch #(.CYCLES(FLASH_CYCLES)) u_flash (
                .clock   (clock),
                .reset   (reset),
                .event_i (event_i[k]),
                .flash_o (flash[k])
            );
        end
    endgenerate

    logic [31:0]   acc_q;
    logic [31:0]   rate_q;
    logic          rate_vld_q;
    logic [GW-1:0] gate_q;
    logic [32:0]   acc_sum;
    logic [31:0]   acc_d;
    logic          gate_last;

    assign acc_sum   = {1'b0, acc_q} + 33'(increment_i);
    assign acc_d     = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
    assign gate_last = (gate_q == GW'(GATE_CYCLES - 1));

    // The terminal cycle's increment is folded into the published rate,
    // so each window covers exactly GATE_CYCLES increments.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q      <= '0;
            rate_q     <= '0;
            rate_vld_q <= 1'b0;
            gate_q     <= '0;
        end else begin
            rate_vld_q <= gate_last;
            if (gate_last) begin
                rate_q <= acc_d;
                acc_q  <= '0;
                gate_q <= '0;
            end else begin
                acc_q  <= acc_d;
                gate_q <= gate_q + GW'(1);
            end
        end
    end

    assign rate_o       = rate_q;
    assign rate_valid_o = rate_vld_q;

    // Bit i of the thermometer is lit when rate >= 2^i, i.e. bit-length > i.
    logic [BAR_WIDTH-1:0] bar_d;
    logic [BAR_WIDTH-1:0] bar_q;

    always_comb begin
        bar_d = '0;
        for (int i = 0; i < BAR_WIDTH; i++) begin
            bar_d[i] = ((rate_q >> i) != 32'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bar_q <= '0;
        end else begin
            bar_q <= bar_d;
        end
    end

    logic [SW-1:0] div_q;
    logic [PW-1:0] pos_q;
    dir_e          dir_q;
    logic          step;

    assign step = (div_q == SW'(SCAN_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
            pos_q <= '0;
            dir_q <= DIR_UP;
        end else begin
            div_q <= step ? '0 : div_q + SW'(1);
            if (step && BAR_WIDTH > 1) begin
                if (dir_q == DIR_UP) begin
                    if (pos_q == PW'(BAR_WIDTH - 1)) begin
                        dir_q <= DIR_DOWN;
                        pos_q <= pos_q - PW'(1);
                    end else begin
                        pos_q <= pos_q + PW'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        dir_q <= DIR_UP;
                        pos_q <= pos_q + PW'(1);
                    end else begin
                        pos_q <= pos_q - PW'(1);
                    end
                end
            end
        end
    end

    logic [BAR_WIDTH-1:0] scan;
    assign scan = BAR_WIDTH'(1) << pos_q;

    // Clear beats a coincident increment so a resync always re-arms the scanner.
    logic seen_q;

    always_ff @(posedge clock) begin
        if (reset || auto_clear_i) begin
            seen_q <= 1'b0;
        end else if (increment_i != '0) begin
            seen_q <= 1'b1;
        end
    end

    logic [PWM_BITS-1:0] pwm_q;
    logic                pwm_en;

    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + PWM_BITS'(1);
        end
    end

    assign pwm_en = (&brightness_i) || (pwm_q < brightness_i);

    logic [N_LEDS-1:0] comp_d;
    logic [N_LEDS-1:0] led_d;
    logic [N_LEDS-1:0] led_q;

    always_comb begin
        comp_d = '0;
        case (mode_i)
            M_NORMAL: comp_d = {flash, bar_q};
            M_CYLON:  comp_d = {flash, scan};
            M_AUTO:   comp_d = {flash, (seen_q ? bar_q : scan)};
            M_TEST:   comp_d = '1;
            default:  comp_d = '0;
        endcase
        led_d = comp_d & {N_LEDS{pwm_en}};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_o = led_q;
endmodule

// File: tb/tb_led_display_engine.sv
// Bench for led_display_engine: directed tables/sequences plus random stimulus
// compared every cycle against a history-based reference model.

module tb_led_display_engine;
    localparam int BW = 4, NF = 4, IW = 32, FC = 4, SD = 2, GC = 16, PB = 2;
    localparam int NL = BW + NF;
    localparam int HMAX = 8192;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    mode = '0;
    logic [PB-1:0] bright = '1;
    logic [NF-1:0] ev = '0;
    logic [IW-1:0] inc = '0;
    logic          clr = 1'b0;
    logic [31:0]   rate;
    logic          rvld;
    logic [NL-1:0] led;

    always #5 clock = ~clock;

    led_display_engine #(
        .BAR_WIDTH(BW), .N_FLASH(NF), .INC_WIDTH(IW), .FLASH_CYCLES(FC),
        .SCAN_DIV(SD), .GATE_CYCLES(GC), .PWM_BITS(PB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mode_i       (mode),
        .brightness_i (bright),
        .event_i      (ev),
        .increment_i  (inc),
        .auto_clear_i (clr),
        .rate_o       (rate),
        .rate_valid_o (rvld),
        .led_o        (led)
    );

    int vectors = 0;
    int miscompares = 0;
    int n = 0;  // clock edges since the last reset edge

    logic [2:0]    mode_h [HMAX];
    logic [PB-1:0] br_h   [HMAX];
    logic [NF-1:0] ev_h   [HMAX];
    logic [IW-1:0] inc_h  [HMAX];
    logic          clr_h  [HMAX];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, n);
        end
    endtask

    // Sum of the j-th completed window, saturated to 32 bits.
    function automatic logic [31:0] rate_after(input int j);
        int m;
        longint unsigned s;
        m = j / GC;
        if (m == 0) return 32'd0;
        s = 0;
        for (int e = (m - 1) * GC + 1; e <= m * GC; e++) s += 64'(inc_h[e]);
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    endfunction

    function automatic logic flash_after(input int j, input int k);
        for (int e = j; e >= 1 && e > j - FC; e--)
            if (ev_h[e][k]) return 1'b1;
        return 1'b0;
    endfunction

    // Triangle wave over the number of scan steps taken.
    function automatic int pos_after(input int j);
        int s, p, per;
        per = 2 * (BW - 1);
        s = j / SD;
        p = s % per;
        return (p < BW) ? p : per - p;
    endfunction

    function automatic logic seen_after(input int j);
        for (int e = j; e >= 1; e--) begin
            if (clr_h[e]) return 1'b0;
            if (inc_h[e] != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [BW-1:0] thermo(input logic [31:0] r);
        logic [BW-1:0] t;
        logic [31:0] one;
        one = 32'd1;
        for (int i = 0; i < BW; i++) t[i] = (r >= (one << i));
        return t;
    endfunction

    function automatic logic [NL-1:0] exp_led(input int nn);
        int j;
        logic [BW-1:0] bar, scan, low;
        logic [NF-1:0] fl;
        logic [NL-1:0] c;
        logic en;
        if (nn == 0) return '0;
        j = nn - 1;
        bar = (j == 0) ? '0 : thermo(rate_after(j - 1));
        scan = BW'(1) << pos_after(j);
        for (int k = 0; k < NF; k++) fl[k] = flash_after(j, k);
        low = seen_after(j) ? bar : scan;
        case (mode_h[nn])
            3'd1: c = {fl, bar};
            3'd2: c = {fl, scan};
            3'd3: c = {fl, low};
            3'd4: c = '1;
            default: c = '0;
        endcase
        en = (br_h[nn] == '1) || ((j % (1 << PB)) < int'(br_h[nn]));
        return en ? c : '0;
    endfunction

    task automatic tick();
        @(posedge clock);
        if (reset) begin
            n = 0;
        end else begin
            n++;
            if (n >= HMAX) begin
                $display("FAIL history overflow: got %0d expected below %0d", n, HMAX);
                $fatal(1, "history overflow");
            end
            mode_h[n] = mode; br_h[n] = bright; ev_h[n] = ev; inc_h[n] = inc; clr_h[n] = clr;
        end
        @(negedge clock);
        check("model_rate", 64'(rate), 64'(rate_after(n)));
        check("model_rate_valid", 64'(rvld), 64'(n > 0 && n % GC == 0));
        check("model_led", 64'(led), 64'(exp_led(n)));
    endtask

    task automatic do_reset();
        reset = 1'b1; ev = '0; inc = '0; clr = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0]    mode;
        logic [PB-1:0] br;
        logic [NL-1:0] led;
    } mvec_t;

    initial begin
        mvec_t tbl [8];
        logic [BW-1:0] walk [7];
        int cnt;
        logic found;

        tbl[0] = '{3'd4, 2'd3, 8'hFF};
        tbl[1] = '{3'd0, 2'd3, 8'h00};
        tbl[2] = '{3'd6, 2'd3, 8'h00};
        tbl[3] = '{3'd5, 2'd3, 8'h00};
        tbl[4] = '{3'd7, 2'd3, 8'h00};
        tbl[5] = '{3'd4, 2'd0, 8'h00};
        tbl[6] = '{3'd4, 2'd3, 8'hFF};
        tbl[7] = '{3'd2, 2'd0, 8'h00};
        walk = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

        @(negedge clock);
        do_reset();
        check("reset_led", 64'(led), 64'h0);
        check("reset_rate", 64'(rate), 64'h0);
        check("reset_valid", 64'(rvld), 64'h0);

        // Mode / brightness table: outputs independent of internal state.
        for (int i = 0; i < 8; i++) begin
            mode = tbl[i].mode; bright = tbl[i].br;
            tick();
            check("mode_table", 64'(led), 64'(tbl[i].led));
        end

        // Flash: single pulse, then retrigger three cycles later.
        do_reset();
        mode = 3'd1; bright = 2'd3;
        tick(); tick();
        ev = 4'b0001; tick(); ev = '0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("flash_single", 64'(led[4]), 64'(i <= 4));
        end
        tick(); tick();
        ev = 4'b0001; tick();
        for (int i = 1; i <= 8; i++) begin
            ev = (i == 3) ? 4'b0001 : 4'b0000;
            tick();
            check("flash_retrig", 64'(led[4]), 64'(i <= 7));
        end
        ev = '0;

        // Rate windows and log bar.
        do_reset();
        mode = 3'd1; bright = 2'd3;
        inc = 1;
        for (int i = 1; i <= 16; i++) tick();
        check("rate16_valid", 64'(rvld), 64'h1);
        check("rate16", 64'(rate), 64'd16);
        inc = 0;
        tick();
        check("rate_valid_single", 64'(rvld), 64'h0);
        tick();
        check("bar16", 64'(led[3:0]), 64'hF);
        while (n < 32) tick();
        check("rate0", 64'(rate), 64'd0);
        tick(); tick();
        check("bar0", 64'(led[3:0]), 64'h0);
        while (n < 50) begin
            inc = (n + 1 == 35 || n + 1 == 40) ? 1 : 0;
            tick();
            if (n == 48) check("rate2", 64'(rate), 64'd2);
        end
        check("bar2", 64'(led[3:0]), 64'h3);

        // Saturation and no-wrap.
        do_reset();
        inc = 32'hFFFF_FFFF;
        for (int i = 1; i <= 16; i++) tick();
        check("sat_full", 64'(rate), 64'hFFFF_FFFF);
        while (n < 48) begin
            case (n + 1)
                20, 25: inc = 32'h8000_0000;
                40:     inc = 32'h7FFF_FFFF;
                41:     inc = 32'h0000_0001;
                default: inc = 0;
            endcase
            tick();
            if (n == 32) check("sat_nowrap", 64'(rate), 64'hFFFF_FFFF);
        end
        check("sat_exact", 64'(rate), 64'h8000_0000);
        inc = 0;

        // Cylon walk in AUTO, handover to bar, and re-arm.
        do_reset();
        mode = 3'd3; bright = 2'd3;
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("cylon_walk", 64'(led[3:0]), 64'(walk[(i - 1) / 2]));
        end
        inc = 5; tick(); inc = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = rvld;
        end
        check("auto_window_seen", 64'(found), 64'h1);
        check("auto_rate5", 64'(rate), 64'd5);
        tick(); tick();
        check("auto_bar5", 64'(led[3:0]), 64'h7);
        clr = 1'b1; tick(); clr = 1'b0;
        tick();
        check("auto_clear_scan", 64'($onehot(led[3:0])), 64'h1);
        clr = 1'b1; inc = 5; tick(); clr = 1'b0; inc = 0;
        tick();
        check("auto_clear_wins", 64'($onehot(led[3:0])), 64'h1);
        tick(); tick();
        check("auto_clear_hold", 64'($onehot(led[3:0])), 64'h1);

        // PWM duty at brightness 1.
        do_reset();
        mode = 3'd4; bright = 2'd1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (led == 8'hFF) cnt++;
            else check("pwm_off_level", 64'(led), 64'h0);
        end
        check("pwm_duty", 64'(cnt), 64'd2);

        // Reset in the middle of activity.
        do_reset();
        mode = 3'd2; bright = 2'd3;
        for (int e = 1; e <= 9; e++) begin
            inc = 1; ev = (e == 8) ? 4'b0010 : 4'b0000;
            tick();
        end
        ev = 4'b0011;
        reset = 1'b1; tick();
        check("midreset_led", 64'(led), 64'h0);
        check("midreset_rate", 64'(rate), 64'h0);
        reset = 1'b0; ev = '0;
        tick();
        check("midreset_pos0", 64'(led), 64'h01);
        tick(); tick();
        check("midreset_pos1", 64'(led[3:0]), 64'h2);
        while (n < 16) tick();
        check("midreset_acc", 64'(rate), 64'd16);
        inc = 0;

        // Random stimulus against the reference model.
        for (int i = 0; i < 1500; i++) begin
            int r;
            reset = ($urandom_range(0, 199) == 0);
            mode = 3'($urandom_range(0, 7));
            bright = PB'($urandom_range(0, 3));
            for (int k = 0; k < NF; k++) ev[k] = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            if (r < 4) inc = 0;
            else if (r < 7) inc = IW'($urandom_range(1, 7));
            else if (r < 9) inc = $urandom;
            else inc = 32'hFFFF_FFFF;
            clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
